// File: rtl/led_pkg.sv
// Constants and types shared by the LED chaser and the PWM trail stage.
package led_pkg;

    localparam int LED_WIDTH    = 8;
    localparam int LED_PWM_BITS = 4;

    // Per-channel level action, resolved in priority order load > decay > hold.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_DECAY = 2'd2
    } lvl_act_e;

    function automatic int lmax_of(input int pwm_bits);
        return (1 << pwm_bits) - 1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level with load/saturating decay and the PWM compare.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS   = LED_PWM_BITS,
    parameter int DECAY_STEP = 2
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                load_i,
    input  logic                tick_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o,
    output logic                active_o
);

    localparam logic [PWM_BITS-1:0] LMAX = PWM_BITS'(lmax_of(PWM_BITS));
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

    lvl_act_e            act;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                led_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        act     = ACT_HOLD;
        level_d = level_q;
        if (load_i)      act = ACT_LOAD;
        else if (tick_i) act = ACT_DECAY;

        case (act)
            ACT_LOAD:  level_d = LMAX;
            ACT_DECAY: level_d = (level_q < STEP) ? '0 : level_q - STEP;
            default:   level_d = level_q;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= (level_q > pwm_cnt_i);
        end
    end

    assign led_o    = led_q;
    assign active_o = (level_q != '0);

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-tail PWM stage: synchronises the chaser pattern and fades each LED out stepwise.
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int WIDTH      = LED_WIDTH,
    parameter int PWM_BITS   = LED_PWM_BITS,
    parameter int DECAY_DIV  = 131072,
    parameter int DECAY_STEP = 2
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [WIDTH-1:0] iPAT,
    output logic [WIDTH-1:0] oLED,
    output logic             oANY
);

    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(lmax_of(PWM_BITS) - 1);
    localparam int                  PRE_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_DIV - 1);

    logic [WIDTH-1:0]    s1_q, s2_q;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                tick;
    logic [WIDTH-1:0]    active;
    logic                any_q;

    assign tick      = (pre_q == PRE_LAST);
    assign pre_d     = tick ? '0 : pre_q + PRE_W'(1);
    assign pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);

    // iPAT comes from the divided-clock chaser domain, so it is double-flopped before use.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1_q      <= '0;
            s2_q      <= '0;
            pwm_cnt_q <= '0;
            pre_q     <= '0;
            any_q     <= 1'b0;
        end else begin
            s1_q      <= iPAT;
            s2_q      <= s1_q;
            pwm_cnt_q <= pwm_cnt_d;
            pre_q     <= pre_d;
            any_q     <= |active;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS   (PWM_BITS),
            .DECAY_STEP (DECAY_STEP)
        ) u_ch (
            .iCLK      (iCLK),
            .iRST      (iRST),
            .load_i    (s2_q[g]),
            .tick_i    (tick),
            .pwm_cnt_i (pwm_cnt_q),
            .led_o     (oLED[g]),
            .active_o  (active[g])
        );
    end

    assign oANY = any_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: three configurations checked every cycle against a level/period model.
module tb_led_trail_pwm;

    localparam int PB = 3;
    localparam int LM = 7;
    localparam int NW = 8;
    localparam int ND = 3;

    int div_a  [ND] = '{4, 4, 64};
    int step_a [ND] = '{1, 3, 1};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NW-1:0] pat = '0;
    logic [NW-1:0] led0, led1, led2;
    logic          any0, any1, any2;

    int nchk  = 0;
    int npass = 0;

    // model state: levels per DUT/channel, the two synchroniser stages, edge count since reset
    int            lvl [ND][NW];
    logic [NW-1:0] s1m, s2m;
    logic [NW-1:0] exp_led [ND];
    logic          exp_any [ND];
    int            e;

    always #5 clk = ~clk;

    led_trail_pwm #(.WIDTH(NW), .PWM_BITS(PB), .DECAY_DIV(4), .DECAY_STEP(1)) dut0 (
        .iCLK(clk), .iRST(rst), .iPAT(pat), .oLED(led0), .oANY(any0));
    led_trail_pwm #(.WIDTH(NW), .PWM_BITS(PB), .DECAY_DIV(4), .DECAY_STEP(3)) dut1 (
        .iCLK(clk), .iRST(rst), .iPAT(pat), .oLED(led1), .oANY(any1));
    led_trail_pwm #(.WIDTH(NW), .PWM_BITS(PB), .DECAY_DIV(64), .DECAY_STEP(1)) dut2 (
        .iCLK(clk), .iRST(rst), .iPAT(pat), .oLED(led2), .oANY(any2));

    function automatic logic [NW-1:0] led_of(input int d);
        case (d)
            0:       return led0;
            1:       return led1;
            default: return led2;
        endcase
    endfunction

    function automatic logic any_of(input int d);
        case (d)
            0:       return any0;
            1:       return any1;
            default: return any2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act === expv) npass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < NW; i++) lvl[d][i] = 0;
            exp_led[d] = '0;
            exp_any[d] = 1'b0;
        end
        s1m = '0;
        s2m = '0;
        e   = 0;
    endtask

    // One clock edge: an LED with level L is lit for the first L slots of each LM-slot period.
    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            bit tick;
            bit anyv;
            tick = ((e % div_a[d]) == div_a[d] - 1);
            anyv = 0;
            for (int i = 0; i < NW; i++) begin
                exp_led[d][i] = (lvl[d][i] > (e % LM));
                if (lvl[d][i] != 0) anyv = 1;
                if (s2m[i])    lvl[d][i] = LM;
                else if (tick) lvl[d][i] = (lvl[d][i] > step_a[d]) ? lvl[d][i] - step_a[d] : 0;
            end
            exp_any[d] = anyv;
        end
        s2m = s1m;
        s1m = pat;
        e++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("led_dut%0d", d), led_of(d), exp_led[d]);
            check($sformatf("any_dut%0d", d), any_of(d), exp_any[d]);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst_async_led%0d", d), led_of(d), 0);
            check($sformatf("rst_async_any%0d", d), any_of(d), 0);
        end
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_held_led", led0 | led1 | led2, 0);
        #2 rst = 1'b0;
    endtask

    initial begin
        int seq0[$];
        int seq1[$];
        int since3;
        int hi_cnt;
        bit ok;

        apply_reset();

        repeat (20) begin
            cycle();
            check("dark_after_rst", led0 | led1 | led2, 0);
        end

        // single bit: rises at the 4th edge after capture and stays fully on
        pat = 8'h80;
        repeat (3) cycle();
        repeat (14) begin
            cycle();
            check("solo_led7", led0, 8'h80);
            check("solo_any", any0, 1);
        end

        // release: record level sequences and measure duty cycle at level 3
        pat    = 8'h00;
        seq0   = {lvl[0][7]};
        seq1   = {lvl[1][7]};
        since3 = -1;
        hi_cnt = 0;
        repeat (600) begin
            cycle();
            if (lvl[0][7] != seq0[$]) seq0.push_back(lvl[0][7]);
            if (lvl[1][7] != seq1[$]) seq1.push_back(lvl[1][7]);
            if (since3 >= 0) begin
                since3++;
                if (since3 <= 7 && led2[7]) hi_cnt++;
            end else if (lvl[2][7] == 3) begin
                since3 = 0;
            end
        end
        check("duty_level3", hi_cnt, 3);
        check("step1_seq_len", seq0.size(), 8);
        for (int k = 0; k < seq0.size() && k < 8; k++)
            check($sformatf("step1_seq%0d", k), seq0[k], 7 - k);
        check("step3_seq_len", seq1.size(), 4);
        if (seq1.size() == 4) begin
            check("step3_seq1", seq1[1], 4);
            check("step3_seq2", seq1[2], 1);
            check("step3_seq3", seq1[3], 0);
        end
        check("faded_any0", any0, 0);
        check("faded_any2", any2, 0);

        // held bit across many ticks: load beats tick
        pat = 8'h08;
        repeat (3) cycle();
        repeat (30) begin
            cycle();
            check("hold_led3", led0[3], 1);
        end

        // chaser walk, one bit per 8 cycles
        for (int k = 0; k < 9; k++) begin
            logic [NW-1:0] one;
            one = 8'h80;
            pat = (k == 8) ? one : one >> k;
            repeat (8) cycle();
            if (k == 7) begin
                ok = (lvl[0][0] == LM);
                for (int j = 1; j < NW; j++)
                    if (lvl[0][j - 1] > 0 ? !(lvl[0][j] < lvl[0][j - 1]) : (lvl[0][j] != 0)) ok = 0;
                check("trail_order", ok, 1);
            end
        end

        // all ones: constant full drive, then reset mid-fade
        pat = 8'hFF;
        repeat (5) cycle();
        check("all_on_led", led0, 8'hFF);
        check("all_on_any", any0, 1);
        pat = 8'h00;
        cycle();
        check("pre_rst_any", any0, 1);
        apply_reset();
        repeat (20) begin
            cycle();
            check("dark_after_midrst", led0 | led1 | led2, 0);
            check("dark_any_midrst", any0 | any1 | any2, 0);
        end

        // randomized patterns
        repeat (60) begin
            pat = NW'($urandom);
            repeat ($urandom_range(1, 12)) cycle();
        end
        pat = 8'h00;
        repeat (40) cycle();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/led_trail_pwm.md
Name: led_trail_pwm

Overview:
- Downstream stage of the running-light LED chaser.
- Takes the chaser's 8-bit pattern and drives the board LEDs through per-LED PWM, producing a fading "comet tail".
- An LED whose pattern bit is set lights at full brightness. When the bit clears, that LED's brightness decays stepwise to off.
- Sits between the chaser register and the LED pins. It runs on the board clock and treats the pattern as an asynchronous input, because the chaser updates on a divided clock.

Parameters:
- WIDTH, 8, number of LED channels (pattern and output width).
- PWM_BITS, 4, brightness resolution. Level range is 0..LMAX, where LMAX = 2**PWM_BITS-1.
- DECAY_DIV, 131072, board-clock cycles per decay tick. Legal range >= 1.
- DECAY_STEP, 2, level decrement per decay tick. Legal range 1..LMAX.

Ports:
- iCLK  input  1  board clock; all state on its rising edge.
- iRST  input  1  asynchronous, active-high reset.
- iPAT  input  WIDTH  LED pattern from the chaser; asynchronous to iCLK.
- oLED  output  WIDTH  PWM-modulated LED drive, registered.
- oANY  output  1  registered; 1 when any channel level is nonzero.

Behaviour:

Reset:
- iRST=1 clears immediately, without waiting for a clock edge: sync flops, levels, pwm_cnt, decay prescaler, oLED=0, oANY=0.
- Reset mid-fade discards all levels. After release, the block restarts from dark.

Synchronizer:
- iPAT passes through 2 flops per bit (s1, s2). Only s2 is used internally.

PWM counter:
- pwm_cnt is PWM_BITS wide and counts 0..LMAX-1, then wraps to 0.
- Period is LMAX cycles (15 at default).

Decay prescaler:
- pre counts 0..DECAY_DIV-1 and wraps.
- tick=1 in the cycle where pre==DECAY_DIV-1.
- DECAY_DIV=1 gives tick every cycle.

Level update, per channel i, each cycle, in priority order:
1. s2[i]=1: level[i] <= LMAX. Load beats a tick in the same cycle.
2. Else if tick: level[i] <= level[i]-DECAY_STEP, saturating at 0. If level[i] < DECAY_STEP, the result is 0. No wrap-around.
3. Else: hold.

Output:
- oLED[i] <= (level[i] > pwm_cnt).
- Level 0 is always off. Level LMAX is always on. Level L is high for exactly L cycles of every LMAX-cycle period.
- oANY <= OR of (level[i] != 0).

Latency:
- iPAT[i] rises and is first captured into s1 at edge n. Then s2 at n+1, level=LMAX at n+2, oLED[i]=1 at n+3.
- A falling bit keeps its level until the next tick.

Simultaneous events:
- All channels update independently in the same cycle; no arbitration.
- iPAT all-ones drives all outputs constantly on.
- iPAT all-zeros decays every channel in parallel.
- Glitches shorter than one iCLK period may be missed. This is acceptable.

Decomposition:
- Shared package led_pkg: constants LED_WIDTH=8, LED_PWM_BITS=4, and the LMAX derivation function. The chaser uses LED_WIDTH from here too.
- Sub-module led_pwm_channel: one level register, load/decay/saturate logic and the output compare. Instantiated WIDTH times via generate.
- Top level holds: synchronizer, shared pwm_cnt, prescaler, oANY.

Test Plan (PWM_BITS=3 so LMAX=7, DECAY_DIV=4, DECAY_STEP=1, WIDTH=8 unless noted):
- Assert iRST mid-run with levels nonzero -> oLED=0 and oANY=0 before the next iCLK edge. Every channel stays dark for 20 cycles after release with iPAT=0.
- iPAT=8'h80 captured at edge n -> oLED[7]=1 from edge n+3, held constantly high over 14 cycles. oLED[6:0]=0 throughout, oANY=1.
- Set iPAT[7]=1, then 0 -> level steps 7,6,5...0, one step per 4 cycles. At level 3, oLED[7] is high 3 of every 7 cycles. After 7 ticks the level is 0 and oANY drops.
- DECAY_STEP=3, start from level 7 -> levels 4, 1, 0 on successive ticks; never wraps to 6.
- Hold iPAT[3]=1 across many ticks -> level stays 7 and oLED[3] is constant 1, confirming load beats tick.
- Chaser-style sequence 80,40,20 ... 01, 80, one bit per 8 cycles -> the leading LED is at 7 and trailing LEDs read strictly decreasing levels. Compare every cycle against a reference model.
